// File: rtl/memory_controller_pkg.sv
// Shared definitions for the byte-serial memory controller: op codes, FSM states,
// IO-space decode constants and the access-length / load-extension helpers.
package memory_controller_pkg;

    localparam int         IO_ADDR_BIT_DEF = 17;
    localparam logic [1:0] IO_SPACE        = 2'b11;

    localparam logic [6:0] OP_LB  = 7'd1;
    localparam logic [6:0] OP_LH  = 7'd2;
    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_LBU = 7'd4;
    localparam logic [6:0] OP_LHU = 7'd5;
    localparam logic [6:0] OP_SB  = 7'd6;
    localparam logic [6:0] OP_SH  = 7'd7;
    localparam logic [6:0] OP_SW  = 7'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    function automatic logic [2:0] op_len(input logic [6:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
            default:              op_len = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [6:0] op, input logic [31:0] raw);
        case (op)
            OP_LB:   load_ext = {{24{raw[7]}}, raw[7:0]};
            OP_LH:   load_ext = {{16{raw[15]}}, raw[15:0]};
            OP_LBU:  load_ext = {24'd0, raw[7:0]};
            OP_LHU:  load_ext = {16'd0, raw[15:0]};
            default: load_ext = raw;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller.sv
// Serialises instruction fetches and load/store requests onto the single byte-wide
// RAM/IO port, little-endian, and returns one assembled result with a 1-cycle valid.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int IO_ADDR_BIT = IO_ADDR_BIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        wrong_commit,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        ifetch_enable,
    input  logic [31:0] ifetch_addr,
    output logic        ifetch_valid,
    output logic [31:0] ifetch_data,
    input  logic        ls_enable,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_data,
    input  logic        ls_is_load,
    input  logic [6:0]  ls_op,
    output logic        ls_valid,
    output logic [31:0] ls_res
);

    state_e      state_q;
    logic [2:0]  k_q;
    logic [2:0]  len_q;
    logic [31:0] base_q;
    logic [31:0] data_q;
    logic [6:0]  op_q;
    logic [31:0] res_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        ifetch_valid_q;
    logic [31:0] ifetch_data_q;
    logic        ls_valid_q;
    logic [31:0] ls_res_q;
    logic [7:0]  din_q;
    logic        prev_rdy_q;

    logic        io_stall_s;
    logic [7:0]  din_s;
    logic [1:0]  slot_s;
    logic [1:0]  nslot_s;
    logic [31:0] asm_s;
    logic [7:0]  st_byte_s;
    logic [31:0] next_a_s;
    logic        accept_s;

    assign io_stall_s = (state_q == ST_STORE) && io_buffer_full
                        && (mem_a_q[IO_ADDR_BIT -: 2] == IO_SPACE);
    // The RAM keeps reading while frozen, so the byte for the last active address is held.
    assign din_s      = prev_rdy_q ? mem_din : din_q;
    assign slot_s     = k_q[1:0] - 2'd1;
    assign nslot_s    = k_q[1:0] + 2'd1;
    assign next_a_s   = base_q + {29'd0, k_q} + 32'd1;
    assign accept_s   = !ifetch_valid_q && !ls_valid_q && !wrong_commit
                        && (ls_enable || ifetch_enable);

    // Merge the byte returned this cycle into the partially assembled word.
    always_comb begin
        asm_s = res_q;
        case (slot_s)
            2'd0:    asm_s[7:0]   = din_s;
            2'd1:    asm_s[15:8]  = din_s;
            2'd2:    asm_s[23:16] = din_s;
            default: asm_s[31:24] = din_s;
        endcase
    end

    // Select the store byte for the next write slot.
    always_comb begin
        st_byte_s = 8'd0;
        case (nslot_s)
            2'd0:    st_byte_s = data_q[7:0];
            2'd1:    st_byte_s = data_q[15:8];
            2'd2:    st_byte_s = data_q[23:16];
            default: st_byte_s = data_q[31:24];
        endcase
    end

    // Request FSM, byte counter and registered port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            k_q            <= 3'd0;
            len_q          <= 3'd0;
            base_q         <= 32'd0;
            data_q         <= 32'd0;
            op_q           <= 7'd0;
            res_q          <= 32'd0;
            mem_a_q        <= 32'd0;
            mem_dout_q     <= 8'd0;
            mem_wr_q       <= 1'b0;
            ifetch_valid_q <= 1'b0;
            ifetch_data_q  <= 32'd0;
            ls_valid_q     <= 1'b0;
            ls_res_q       <= 32'd0;
            din_q          <= 8'd0;
            prev_rdy_q     <= 1'b0;
        end else begin
            din_q      <= din_s;
            prev_rdy_q <= rdy;
            if (rdy) begin
                ifetch_valid_q <= 1'b0;
                ls_valid_q     <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        mem_wr_q <= 1'b0;
                        mem_a_q  <= 32'd0;
                        if (accept_s) begin
                            k_q   <= 3'd0;
                            res_q <= 32'd0;
                            if (ls_enable) begin
                                base_q  <= ls_addr;
                                data_q  <= ls_data;
                                op_q    <= ls_op;
                                len_q   <= op_len(ls_op);
                                mem_a_q <= ls_addr;
                                if (ls_is_load) begin
                                    state_q <= ST_LOAD;
                                end else begin
                                    state_q    <= ST_STORE;
                                    mem_dout_q <= ls_data[7:0];
                                    mem_wr_q   <= 1'b1;
                                end
                            end else begin
                                base_q  <= ifetch_addr;
                                op_q    <= OP_LW;
                                len_q   <= 3'd4;
                                mem_a_q <= ifetch_addr;
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH, ST_LOAD: begin
                        if (wrong_commit) begin
                            state_q  <= ST_IDLE;
                            k_q      <= 3'd0;
                            mem_a_q  <= 32'd0;
                            mem_wr_q <= 1'b0;
                        end else begin
                            if (k_q != 3'd0) begin
                                res_q <= asm_s;
                            end
                            if (k_q == len_q) begin
                                state_q <= ST_IDLE;
                                k_q     <= 3'd0;
                                mem_a_q <= 32'd0;
                                if (state_q == ST_FETCH) begin
                                    ifetch_valid_q <= 1'b1;
                                    ifetch_data_q  <= asm_s;
                                end else begin
                                    ls_valid_q <= 1'b1;
                                    ls_res_q   <= load_ext(op_q, asm_s);
                                end
                            end else begin
                                k_q     <= k_q + 3'd1;
                                mem_a_q <= ((k_q + 3'd1) < len_q) ? next_a_s : 32'd0;
                            end
                        end
                    end
                    ST_STORE: begin
                        if (!io_stall_s) begin
                            if (k_q == (len_q - 3'd1)) begin
                                state_q    <= ST_IDLE;
                                k_q        <= 3'd0;
                                mem_a_q    <= 32'd0;
                                mem_dout_q <= 8'd0;
                                mem_wr_q   <= 1'b0;
                                ls_valid_q <= 1'b1;
                                ls_res_q   <= 32'd0;
                            end else begin
                                k_q        <= k_q + 3'd1;
                                mem_a_q    <= next_a_s;
                                mem_dout_q <= st_byte_s;
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        mem_wr_q <= 1'b0;
                        mem_a_q  <= 32'd0;
                    end
                endcase
            end
        end
    end

    assign mem_a        = mem_a_q;
    assign mem_dout     = mem_dout_q;
    assign mem_wr       = mem_wr_q && rdy && !io_stall_s;
    assign ifetch_valid = ifetch_valid_q;
    assign ifetch_data  = ifetch_data_q;
    assign ls_valid     = ls_valid_q;
    assign ls_res       = ls_res_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed and randomized checks of memory_controller against a transaction-level
// reference memory model with arithmetic load extension.
module tb_memory_controller;
    import memory_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        wrong_commit = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        ifetch_enable = 1'b0;
    logic [31:0] ifetch_addr = 32'd0;
    logic        ifetch_valid;
    logic [31:0] ifetch_data;
    logic        ls_enable = 1'b0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_data = 32'd0;
    logic        ls_is_load = 1'b0;
    logic [6:0]  ls_op = 7'd0;
    logic        ls_valid;
    logic [31:0] ls_res;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_mode = 1'b0;

    logic [7:0]  ram     [bit [31:0]];
    logic [7:0]  ref_mem [bit [31:0]];
    logic [31:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [31:0] addr_log[$];

    memory_controller dut (
        .clk(clk), .rst(rst), .rdy(rdy), .wrong_commit(wrong_commit),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .ifetch_enable(ifetch_enable),
        .ifetch_addr(ifetch_addr), .ifetch_valid(ifetch_valid), .ifetch_data(ifetch_data),
        .ls_enable(ls_enable), .ls_addr(ls_addr), .ls_data(ls_data),
        .ls_is_load(ls_is_load), .ls_op(ls_op), .ls_valid(ls_valid), .ls_res(ls_res)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : pat(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    // Byte-wide RAM: registered read of the address presented this cycle.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram_rd(mem_a);
    end

    // Log every byte actually written to the port.
    always @(negedge clk) begin
        #1;
        if (mem_wr) begin
            wr_a.push_back(mem_a);
            wr_d.push_back(mem_dout);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    function automatic int ref_len(input logic [6:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [6:0] op, input logic [31:0] addr);
        longint v;
        int     n;
        n = ref_len(op);
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_rd(addr + 32'(i)));
        if ((op == OP_LB || op == OP_LH) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic check_writes(input logic [31:0] addr, input logic [31:0] data, input int n);
        check_eq("wr_count", 32'(wr_a.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wr_a.size()) begin
                check_eq("wr_addr", wr_a[i], addr + 32'(i));
                check_eq("wr_data", {24'd0, wr_d[i]}, (data >> (8 * i)) & 32'hFF);
            end
            ref_mem[addr + 32'(i)] = 8'((data >> (8 * i)) & 32'hFF);
        end
    endtask

    task automatic run_req(input bit is_fetch, input bit is_load, input logic [6:0] op,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int stall_cyc, input int wc_at,
                           output logic [31:0] res, output int lat);
        bit done;
        bit both;
        done = 1'b0;
        both = 1'b0;
        res  = 32'd0;
        lat  = 0;
        wr_a.delete();
        wr_d.delete();
        addr_log.delete();
        if (is_fetch) begin
            ifetch_enable = 1'b1;
            ifetch_addr   = addr;
        end else begin
            ls_enable  = 1'b1;
            ls_addr    = addr;
            ls_data    = data;
            ls_is_load = is_load;
            ls_op      = op;
        end
        io_buffer_full = (stall_cyc > 0);
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            addr_log.push_back(mem_a);
            if (ifetch_valid && ls_valid) both = 1'b1;
            if (is_fetch ? ifetch_valid : ls_valid) begin
                done = 1'b1;
                res  = is_fetch ? ifetch_data : ls_res;
            end
            if (done) begin
                ifetch_enable  = 1'b0;
                ls_enable      = 1'b0;
                rdy            = 1'b1;
                io_buffer_full = 1'b0;
                wrong_commit   = 1'b0;
            end else if (rand_mode) begin
                rdy            = ($urandom_range(0, 3) != 0);
                io_buffer_full = ($urandom_range(0, 1) != 0);
                wrong_commit   = 1'b0;
            end else begin
                io_buffer_full = (lat <= stall_cyc);
                wrong_commit   = (lat == wc_at);
            end
        end
        check_eq("req_done", {31'd0, done}, 32'd1);
        check_eq("valid_excl", {31'd0, both}, 32'd0);
        ifetch_enable  = 1'b0;
        ls_enable      = 1'b0;
        rdy            = 1'b1;
        io_buffer_full = 1'b0;
        wrong_commit   = 1'b0;
        @(negedge clk);
        check_eq("pulse_width", {30'd0, ifetch_valid, ls_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        int          cnt;
        bit          seen;
        logic [6:0]  ld_ops[5];
        logic [6:0]  st_ops[3];
        ld_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        st_ops = '{OP_SB, OP_SH, OP_SW};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mem_a", mem_a, 32'd0);
        check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check_eq("rst_valids", {30'd0, ifetch_valid, ls_valid}, 32'd0);
        check_eq("rst_ifetch_data", ifetch_data, 32'd0);
        check_eq("rst_ls_res", ls_res, 32'd0);

        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        poke(32'h200, 8'h80); poke(32'h201, 8'h7F);

        run_req(1'b0, 1'b1, OP_LW, 32'h100, 32'd0, 0, 0, res, lat);
        check_eq("lw_res", res, 32'h1234_5678);
        check_eq("lw_latency", 32'(lat), 32'd6);
        for (int i = 0; i < 4; i++) check_eq("lw_addr", addr_log[i], 32'h100 + 32'(i));

        run_req(1'b0, 1'b1, OP_LB, 32'h200, 32'd0, 0, 0, res, lat);
        check_eq("lb_res", res, 32'hFFFF_FF80);
        check_eq("lb_latency", 32'(lat), 32'd3);
        run_req(1'b0, 1'b1, OP_LBU, 32'h200, 32'd0, 0, 0, res, lat);
        check_eq("lbu_res", res, 32'h0000_0080);
        run_req(1'b0, 1'b1, OP_LH, 32'h200, 32'd0, 0, 0, res, lat);
        check_eq("lh_res", res, 32'h0000_7F80);

        run_req(1'b0, 1'b0, OP_SH, 32'h300, 32'hAABB_CCDD, 0, 0, res, lat);
        check_eq("sh_res", res, 32'd0);
        check_eq("sh_latency", 32'(lat), 32'd3);
        check_writes(32'h300, 32'hAABB_CCDD, 2);

        // Simultaneous requests: the load-store buffer wins, the fetch follows after cooldown.
        ls_enable = 1'b1; ls_is_load = 1'b1; ls_op = OP_LW; ls_addr = 32'h100;
        ifetch_enable = 1'b1; ifetch_addr = 32'h200;
        seen = 1'b0; cnt = 0;
        while (!ls_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (ifetch_valid) seen = 1'b1;
        end
        check_eq("arb_ls_valid", {31'd0, ls_valid}, 32'd1);
        check_eq("arb_no_early_fetch", {31'd0, seen}, 32'd0);
        check_eq("arb_ls_res", ls_res, 32'h1234_5678);
        ls_enable = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ifetch_valid && cnt < 50);
        ifetch_enable = 1'b0;
        check_eq("arb_fetch_latency", 32'(cnt), 32'd7);
        check_eq("arb_fetch_data", ifetch_data, ref_load(OP_LW, 32'h200));
        @(negedge clk);

        run_req(1'b0, 1'b0, OP_SB, 32'h0003_0000, 32'h0000_00C3, 3, 0, res, lat);
        check_eq("io_sb_latency", 32'(lat), 32'd5);
        check_writes(32'h0003_0000, 32'h0000_00C3, 1);

        // Flush during the second byte of a fetch.
        ifetch_enable = 1'b1; ifetch_addr = 32'h100;
        repeat (2) @(negedge clk);
        wrong_commit = 1'b1; ifetch_enable = 1'b0;
        @(negedge clk);
        wrong_commit = 1'b0;
        check_eq("abort_mem_a", mem_a, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ifetch_valid) seen = 1'b1;
            @(negedge clk);
        end
        check_eq("abort_no_valid", {31'd0, seen}, 32'd0);
        run_req(1'b1, 1'b0, OP_LW, 32'h100, 32'd0, 0, 0, res, lat);
        check_eq("fetch_res", res, 32'h1234_5678);
        check_eq("fetch_latency", 32'(lat), 32'd6);

        run_req(1'b0, 1'b0, OP_SW, 32'h500, 32'hDEAD_BEEF, 0, 2, res, lat);
        check_eq("sw_wc_res", res, 32'd0);
        check_writes(32'h500, 32'hDEAD_BEEF, 4);

        run_req(1'b0, 1'b1, OP_LW, 32'hFFFF_FFFE, 32'd0, 0, 0, res, lat);
        check_eq("wrap_res", res, ref_load(OP_LW, 32'hFFFF_FFFE));
        check_eq("wrap_addr2", addr_log[2], 32'd0);
        check_eq("wrap_addr3", addr_log[3], 32'd1);

        // Reset in the middle of a store aborts the remaining bytes.
        wr_a.delete(); wr_d.delete();
        ls_enable = 1'b1; ls_is_load = 1'b0; ls_op = OP_SW; ls_addr = 32'h400; ls_data = 32'h1122_3344;
        repeat (2) @(negedge clk);
        rst = 1'b1; ls_enable = 1'b0;
        @(negedge clk);
        check_eq("mrst_mem_a", mem_a, 32'd0);
        check_eq("mrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("mrst_ifetch_data", ifetch_data, 32'd0);
        check_eq("mrst_valids", {30'd0, ifetch_valid, ls_valid}, 32'd0);
        check_writes(32'h400, 32'h0000_3344, 2);
        rst = 1'b0;
        @(negedge clk);

        rand_mode = 1'b1;
        for (int t = 0; t < 120; t++) begin
            int          kind;
            logic [31:0] a;
            logic [31:0] d;
            logic [6:0]  op;
            kind = $urandom_range(0, 2);
            a = (($urandom_range(0, 1) != 0) ? 32'h0003_0000 : 32'h0000_0000) + 32'($urandom_range(0, 63));
            d = $urandom;
            if (kind == 0) begin
                run_req(1'b1, 1'b0, OP_LW, a, 32'd0, 0, 0, res, lat);
                check_eq("rnd_fetch", res, ref_load(OP_LW, a));
            end else if (kind == 1) begin
                op = ld_ops[$urandom_range(0, 4)];
                run_req(1'b0, 1'b1, op, a, 32'd0, 0, 0, res, lat);
                check_eq("rnd_load", res, ref_load(op, a));
            end else begin
                op = st_ops[$urandom_range(0, 2)];
                run_req(1'b0, 1'b0, op, a, d, 0, 0, res, lat);
                check_eq("rnd_store_res", res, 32'd0);
                check_writes(a, d, ref_len(op));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
